// File: rtl/spi_rx_deser.sv
// SPI receive deserializer: oversamples cs/sclk/data in the clk domain, rebuilds
// MSB-first DATA_W-bit frames and hands each word over through a one-word valid/ready buffer.
module spi_rx_deser #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_l,
  input  logic              spi_sclk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              frame_err,
  output logic [4:0]        bit_count
);

  typedef enum logic [1:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);
  localparam logic [1:0] FILL_MAX = 2'(SYNC_STAGES);

  logic s_cs;
  logic s_sclk;
  logic s_data;

  // Synchronizer packs {cs, sclk, data} per stage; idle value is cs=1, sclk=0, data=0.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_cs   = spi_cs_l;
    assign s_sclk = spi_sclk;
    assign s_data = spi_data;
  end else begin : g_sync
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = {spi_cs_l, spi_sclk, spi_data};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          sync_q[i] <= 3'b100;
        end
      end else begin
        sync_q <= sync_d;
      end
    end

    assign s_cs   = sync_q[SYNC_STAGES-1][2];
    assign s_sclk = sync_q[SYNC_STAGES-1][1];
    assign s_data = sync_q[SYNC_STAGES-1][0];
  end

  logic              s_sclk_d_q;
  logic              s_sclk_d_d;
  logic              rise;
  logic [1:0]        fill_q;
  logic [1:0]        fill_d;
  logic              fill_done;
  state_t            state_q;
  state_t            state_d;
  logic [4:0]        bit_cnt_q;
  logic [4:0]        bit_cnt_d;
  logic [DATA_W-2:0] shreg_q;
  logic [DATA_W-2:0] shreg_d;
  logic              word_done;
  logic              ferr_q;
  logic              ferr_d;
  logic [DATA_W-1:0] rx_data_q;
  logic [DATA_W-1:0] rx_data_d;
  logic              rx_valid_q;
  logic              rx_valid_d;
  logic              ovr_q;
  logic              ovr_d;

  assign s_sclk_d_d = s_sclk;
  assign rise       = s_sclk & ~s_sclk_d_q;

  // The synchronizer still shows reset idle values until it has been refilled from
  // the pins; trusting s_cs earlier would let a frame in progress slip past RESYNC.
  assign fill_done = (fill_q == FILL_MAX);
  assign fill_d    = fill_done ? fill_q : fill_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      ST_RESYNC: begin
        bit_cnt_d = '0;
        if (s_cs && fill_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        bit_cnt_d = '0;
        shreg_d   = '0;
        if (!s_cs) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (s_cs) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          ferr_d    = (bit_cnt_q != 5'd0);
        end else if (rise) begin
          shreg_d   = {shreg_q[DATA_W-3:0], s_data};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (s_cs) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else if (rise) begin
          ferr_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_RESYNC;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Holding register: a completed word replaces the old one only if the old one leaves now.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = 1'b0;
    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = {shreg_q, s_data};
        rx_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_sclk_d_q <= 1'b0;
      fill_q     <= '0;
      state_q    <= ST_RESYNC;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ferr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      s_sclk_d_q <= s_sclk_d_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ferr_q     <= ferr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = ovr_q;
  assign frame_err  = ferr_q;
  assign bit_count  = bit_cnt_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Bench for spi_rx_deser: a 2-stage and a 0-stage instance share the SPI pins;
// expected words go into a queue and are compared at each handshake.
module tb_spi_rx_deser;

  logic        clk;
  logic        reset;
  logic        spi_cs_l;
  logic        spi_sclk;
  logic        spi_data;
  logic        rx_ready;
  logic        rx_ready0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err;
  logic [4:0]  bit_count;
  logic [15:0] rx_data0;
  logic        rx_valid0;
  logic        rx_overrun0;
  logic        frame_err0;
  logic [4:0]  bit_count0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          hs_count, ovr_count, ferr_count;
  int          v_rise_cyc, v0_rise_cyc;
  int          last_edge;
  logic [15:0] v0_data;
  logic [15:0] exp_q[$];

  spi_rx_deser #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk),
    .spi_data(spi_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .frame_err(frame_err),
    .bit_count(bit_count)
  );

  spi_rx_deser #(.DATA_W(16), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk),
    .spi_data(spi_data), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .rx_overrun(rx_overrun0), .frame_err(frame_err0),
    .bit_count(bit_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Master-style frame: low phase carries data, high phase one cycle, cs high one cycle after.
  task automatic send_bits(input logic [15:0] w, input int nbits, input bit end_cs);
    spi_cs_l = 1'b0;
    for (int i = 15; i > 15 - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_data = w[i];
      tick();
      spi_sclk  = 1'b1;
      last_edge = cyc + 1;
      tick();
    end
    spi_sclk = 1'b0;
    if (end_cs) begin
      spi_cs_l = 1'b1;
      tick();
    end
  endtask

  task automatic clear_counts();
    hs_count    = 0;
    ovr_count   = 0;
    ferr_count  = 0;
    v_rise_cyc  = -1;
    v0_rise_cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    checks++;
    if ({rx_valid, rx_overrun, frame_err} !== 3'b000 || rx_data !== 16'h0 || bit_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b ovr=%b ferr=%b data=%h cnt=%0d, required all zero",
               rx_valid, rx_overrun, frame_err, rx_data, bit_count);
    end
    reset = 1'b1;
    idle(6);
  endtask

  task automatic test_single();
    clear_counts();
    rx_ready = 1'b1;
    exp_q.push_back(16'hA5C3);
    send_bits(16'hA5C3, 16, 1'b0);
    idle(3);
    checks++;
    if (v_rise_cyc - last_edge !== 2) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required 2", v_rise_cyc - last_edge);
    end
    checks++;
    if (bit_count !== 5'd16) begin
      errors++;
      $display("FAIL single_bitcount: got %0d, required 16", bit_count);
    end
    // one extra sclk edge while cs is still low
    spi_sclk = 1'b1;
    tick();
    spi_sclk = 1'b0;
    idle(4);
    checks++;
    if (ferr_count !== 1 || bit_count !== 5'd16) begin
      errors++;
      $display("FAIL extra_edge: got ferr=%0d cnt=%0d, required ferr=1 cnt=16", ferr_count, bit_count);
    end
    spi_cs_l = 1'b1;
    idle(4);
    checks++;
    if (bit_count !== 5'd0 || hs_count !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL single_end: got cnt=%0d words=%0d pending=%0d, required 0/1/0",
               bit_count, hs_count, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    rx_ready = 1'b1;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'hFFFF);
    send_bits(16'h0001, 16, 1'b1);
    send_bits(16'h8000, 16, 1'b1);
    send_bits(16'hFFFF, 16, 1'b1);
    idle(5);
    checks++;
    if (hs_count !== 3 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_words: got %0d words, %0d pending, required 3/0", hs_count, exp_q.size());
    end
    checks++;
    if (ovr_count !== 0 || ferr_count !== 0) begin
      errors++;
      $display("FAIL b2b_flags: got ovr=%0d ferr=%0d, required 0/0", ovr_count, ferr_count);
    end
  endtask

  task automatic test_overrun();
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_bits(16'h1234, 16, 1'b1);
    send_bits(16'h5678, 16, 1'b1);
    idle(5);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 16'h1234) begin
      errors++;
      $display("FAIL ovr_hold: got valid=%b data=%h, required 1/1234", rx_valid, rx_data);
    end
    checks++;
    if (ovr_count !== 1 || hs_count !== 0) begin
      errors++;
      $display("FAIL ovr_pulse: got ovr=%0d words=%0d, required 1/0", ovr_count, hs_count);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    idle(2);
    checks++;
    if (hs_count !== 1 || rx_valid !== 1'b0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL ovr_drain: got words=%0d valid=%b pending=%0d, required 1/0/0",
               hs_count, rx_valid, exp_q.size());
    end
    rx_ready = 1'b1;
  endtask

  task automatic test_abort();
    clear_counts();
    send_bits(16'hBEEF, 7, 1'b1);
    idle(5);
    checks++;
    if (ferr_count !== 1 || hs_count !== 0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_err: got ferr=%0d words=%0d valid=%b, required 1/0/0",
               ferr_count, hs_count, rx_valid);
    end
    exp_q.push_back(16'h00FF);
    send_bits(16'h00FF, 16, 1'b1);
    idle(5);
    checks++;
    if (hs_count !== 1 || ferr_count !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_next: got words=%0d ferr=%0d pending=%0d, required 1/1/0",
               hs_count, ferr_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    send_bits(16'hFFFF, 5, 1'b0);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    checks++;
    if (bit_count !== 5'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got cnt=%0d valid=%b, required 0/0", bit_count, rx_valid);
    end
    for (int i = 0; i < 11; i++) begin
      spi_sclk = 1'b0;
      spi_data = i[0];
      tick();
      spi_sclk = 1'b1;
      tick();
    end
    spi_sclk = 1'b0;
    spi_cs_l = 1'b1;
    idle(5);
    checks++;
    if (hs_count !== 0 || ferr_count !== 0) begin
      errors++;
      $display("FAIL midrst_frame: got words=%0d ferr=%0d, required 0/0", hs_count, ferr_count);
    end
    exp_q.push_back(16'h3C3C);
    send_bits(16'h3C3C, 16, 1'b1);
    idle(5);
    checks++;
    if (hs_count !== 1 || ferr_count !== 0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL midrst_next: got words=%0d ferr=%0d pending=%0d, required 1/0/0",
               hs_count, ferr_count, exp_q.size());
    end
  endtask

  task automatic test_zero_sync();
    clear_counts();
    rx_ready = 1'b1;
    exp_q.push_back(16'h7E81);
    send_bits(16'h7E81, 16, 1'b1);
    idle(5);
    checks++;
    if (v0_rise_cyc !== last_edge) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles, required 0", v0_rise_cyc - last_edge);
    end
    checks++;
    if (v0_data !== 16'h7E81) begin
      errors++;
      $display("FAIL zero_data: got %h, required 7e81", v0_data);
    end
    checks++;
    if (v_rise_cyc - last_edge !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_ref2: got latency=%0d pending=%0d, required 2/0",
               v_rise_cyc - last_edge, exp_q.size());
    end
  endtask

  initial begin
    reset     = 1'b0;
    spi_cs_l  = 1'b1;
    spi_sclk  = 1'b0;
    spi_data  = 1'b0;
    rx_ready  = 1'b0;
    rx_ready0 = 1'b1;
    last_edge = 0;
    v0_data   = '0;
    clear_counts();

    fork
      begin : monitor
        logic        prev_v = 1'b0;
        logic        prev_v0 = 1'b0;
        logic [15:0] exp;
        forever begin
          @(negedge clk);
          if (rx_valid === 1'b1 && !prev_v) v_rise_cyc = cyc;
          if (rx_valid0 === 1'b1 && !prev_v0) begin
            v0_rise_cyc = cyc;
            v0_data     = rx_data0;
          end
          prev_v  = (rx_valid === 1'b1);
          prev_v0 = (rx_valid0 === 1'b1);
          if (rx_overrun === 1'b1) ovr_count++;
          if (frame_err === 1'b1) ferr_count++;
          if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL sb_unexpected: got word %h, required no word", rx_data);
            end else begin
              exp = exp_q.pop_front();
              if (rx_data !== exp) begin
                errors++;
                $display("FAIL sb_word: got %h, required %h", rx_data, exp);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_mid_frame();
    test_zero_sync();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
